adsr_envelope_bank: RTL and testbench

//   Bank of N_VOICES independent ADSR envelope generators sharing one set of A/D/S/R controls.

---
 rtl/adsr_envelope_bank.sv | 166 ++++++++++++++++
 tb/tb_adsr_envelope_bank.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope_bank.sv
// adsr_envelope_bank
//   Bank of N_VOICES independent ADSR envelope generators sharing one set of
//   attack/decay/sustain/release controls. Envelopes advance only on sample_tick.
//   Gate edges are captured on every clk into per-voice rise/fall flags. These
//   flags persist until a tick consumes them, so short gate pulses between ticks
//   are not lost.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   sample_tick  one-cycle strobe that paces envelope updates
//   gate         per-voice note gate (bit i = voice i)
//   a, d, s, r   shared attack rate, decay rate, sustain level, release rate
//   amplitude    per-voice amplitude, voice i at [i*AMP_BITS +: AMP_BITS]
//   active       per-voice flag, high while the voice is not idle
module adsr_envelope_bank #(
    parameter int unsigned N_VOICES       = 4,
    parameter int unsigned AMP_BITS       = 8,
    parameter int unsigned ACC_BITS       = 26,
    parameter bit          RETRIGGER_ZERO = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic [N_VOICES-1:0]          gate,
    input  logic [3:0]                   a,
    input  logic [3:0]                   d,
    input  logic [3:0]                   s,
    input  logic [3:0]                   r,
    output logic [N_VOICES*AMP_BITS-1:0] amplitude,
    output logic [N_VOICES-1:0]          active
);

    typedef enum logic [2:0] {
        StIdle,
        StAttack,
        StDecay,
        StSustain,
        StRelease
    } state_e;

    localparam int unsigned SusReps = (ACC_BITS + 3) / 4;
    localparam logic [ACC_BITS-1:0] AccMax  = '1;
    // Rate x maps to 2^(ACC_BITS-1-x), i.e. this constant shifted right by x.
    localparam logic [ACC_BITS-1:0] RateTop = {1'b1, {(ACC_BITS-1){1'b0}}};

    state_e              state_q [N_VOICES];
    state_e              state_d [N_VOICES];
    logic [ACC_BITS-1:0] acc_q   [N_VOICES];
    logic [ACC_BITS-1:0] acc_d   [N_VOICES];
    logic [N_VOICES-1:0] gate_q;
    logic [N_VOICES-1:0] rise_q, rise_d;
    logic [N_VOICES-1:0] fall_q, fall_d;

    logic [ACC_BITS-1:0]  step_a, step_d, step_r, sus;
    logic [4*SusReps-1:0] sus_rep;

    // Shared controls decoded once for all voices.
    always_comb begin
        step_a  = RateTop >> a;
        step_d  = RateTop >> d;
        step_r  = RateTop >> r;
        // Replicating s MSB-first spreads the 4-bit level over the full range (F -> max).
        sus_rep = {SusReps{s}};
        sus     = sus_rep[4*SusReps-1 -: ACC_BITS];
    end

    always_comb begin
        logic [ACC_BITS:0] sum;
        logic [ACC_BITS:0] diff;
        state_d = state_q;
        acc_d   = acc_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        sum     = '0;
        diff    = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            sum  = {1'b0, acc_q[i]} + {1'b0, step_a};
            diff = {1'b0, acc_q[i]} - {1'b0, step_d};
            if (sample_tick) begin
                if (rise_q[i]) begin
                    state_d[i] = StAttack;
                    if (RETRIGGER_ZERO) begin
                        acc_d[i] = '0;
                    end
                    rise_d[i] = 1'b0;
                    // A fall seen after the rise still has to release if the gate stayed low.
                    fall_d[i] = fall_q[i] & ~gate[i];
                end else if (fall_q[i]) begin
                    fall_d[i] = 1'b0;
                    if (state_q[i] inside {StAttack, StDecay, StSustain}) begin
                        state_d[i] = StRelease;
                    end
                end else begin
                    case (state_q[i])
                        StAttack: begin
                            if (sum[ACC_BITS] || (sum[ACC_BITS-1:0] == AccMax)) begin
                                acc_d[i]   = AccMax;
                                state_d[i] = StDecay;
                            end else begin
                                acc_d[i] = sum[ACC_BITS-1:0];
                            end
                        end
                        StDecay: begin
                            // Borrow means we went below zero, hence below any sustain level.
                            if (diff[ACC_BITS] || (diff[ACC_BITS-1:0] <= sus)) begin
                                acc_d[i]   = sus;
                                state_d[i] = StSustain;
                            end else begin
                                acc_d[i] = diff[ACC_BITS-1:0];
                            end
                        end
                        StSustain: begin
                            acc_d[i] = sus;
                        end
                        StRelease: begin
                            if (acc_q[i] <= step_r) begin
                                acc_d[i]   = '0;
                                state_d[i] = StIdle;
                            end else begin
                                acc_d[i] = acc_q[i] - step_r;
                            end
                        end
                        default: begin
                            acc_d[i] = '0;
                        end
                    endcase
                end
            end
            // Edges seen this cycle are held for a later tick.
            rise_d[i] = rise_d[i] | (gate[i] & ~gate_q[i]);
            fall_d[i] = fall_d[i] | (~gate[i] & gate_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_VOICES; i++) begin
                state_q[i] <= StIdle;
                acc_q[i]   <= '0;
            end
            gate_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < N_VOICES; i++) begin
                state_q[i] <= state_d[i];
                acc_q[i]   <= acc_d[i];
            end
            gate_q <= gate;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Outputs are straight slices of registered state, so they change the cycle after a tick.
    always_comb begin
        amplitude = '0;
        active    = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            amplitude[i*AMP_BITS +: AMP_BITS] = acc_q[i][ACC_BITS-1 -: AMP_BITS];
            active[i]                         = (state_q[i] != StIdle);
        end
    end

endmodule

// File: tb/tb_adsr_envelope_bank.sv
// tb_adsr_envelope_bank
//   Drives two envelope banks (restart-from-zero and continue-from-level retrigger)
//   with identical stimulus. Both banks are compared every cycle against a
//   behavioural model of the envelope rules. Directed steps also check known
//   amplitude values.
module tb_adsr_envelope_bank;

    localparam int NV  = 4;
    localparam int AMP = 8;
    localparam int ACC = 26;
    localparam longint MAXV = (longint'(1) << ACC) - 1;
    localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic [NV-1:0]     gate = '0;
    logic [3:0]        a = 4'd0, d = 4'd1, s = 4'd8, r = 4'd1;
    logic [NV*AMP-1:0] amp0, amp1;
    logic [NV-1:0]     act0, act1;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: index 0 restarts from zero on retrigger, index 1 continues.
    int     m_st   [2][NV];
    longint m_acc  [2][NV];
    bit     m_gq   [2][NV];
    bit     m_rise [2][NV];
    bit     m_fall [2][NV];

    adsr_envelope_bank #(
        .N_VOICES(NV), .AMP_BITS(AMP), .ACC_BITS(ACC), .RETRIGGER_ZERO(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .sample_tick(tick), .gate(gate),
        .a(a), .d(d), .s(s), .r(r), .amplitude(amp0), .active(act0)
    );

    adsr_envelope_bank #(
        .N_VOICES(NV), .AMP_BITS(AMP), .ACC_BITS(ACC), .RETRIGGER_ZERO(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .sample_tick(tick), .gate(gate),
        .a(a), .d(d), .s(s), .r(r), .amplitude(amp1), .active(act1)
    );

    always #5 clk = ~clk;

    function automatic longint m_step(input logic [3:0] x);
        return longint'(1) << (ACC - 1 - int'(x));
    endfunction

    // Sustain level: bit k from the top takes s bit (3 - k mod 4).
    function automatic longint m_sus(input logic [3:0] sv);
        longint v = 0;
        for (int k = 0; k < ACC; k++) begin
            v = (v << 1) | longint'(sv[3 - (k % 4)]);
        end
        return v;
    endfunction

    task automatic model_clk();
        longint n;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NV; i++) begin
                bit nr, nf;
                nr = gate[i] && !m_gq[k][i];
                nf = !gate[i] && m_gq[k][i];
                if (rst) begin
                    m_st[k][i] = M_IDLE; m_acc[k][i] = 0; m_gq[k][i] = 0;
                    m_rise[k][i] = 0; m_fall[k][i] = 0;
                end else begin
                    if (tick) begin
                        if (m_rise[k][i]) begin
                            m_st[k][i] = M_ATT;
                            if (k == 0) m_acc[k][i] = 0;
                            m_rise[k][i] = 0;
                            if (gate[i]) m_fall[k][i] = 0;
                        end else if (m_fall[k][i]) begin
                            m_fall[k][i] = 0;
                            if (m_st[k][i] == M_ATT || m_st[k][i] == M_DEC || m_st[k][i] == M_SUS)
                                m_st[k][i] = M_REL;
                        end else begin
                            case (m_st[k][i])
                                M_ATT: begin
                                    n = m_acc[k][i] + m_step(a);
                                    if (n >= MAXV) begin m_acc[k][i] = MAXV; m_st[k][i] = M_DEC; end
                                    else m_acc[k][i] = n;
                                end
                                M_DEC: begin
                                    n = m_acc[k][i] - m_step(d);
                                    if (n <= m_sus(s)) begin
                                        m_acc[k][i] = m_sus(s); m_st[k][i] = M_SUS;
                                    end else m_acc[k][i] = n;
                                end
                                M_SUS: m_acc[k][i] = m_sus(s);
                                M_REL: begin
                                    if (m_acc[k][i] <= m_step(r)) begin
                                        m_acc[k][i] = 0; m_st[k][i] = M_IDLE;
                                    end else m_acc[k][i] = m_acc[k][i] - m_step(r);
                                end
                                default: m_acc[k][i] = 0;
                            endcase
                        end
                    end
                    m_rise[k][i] = m_rise[k][i] | nr;
                    m_fall[k][i] = m_fall[k][i] | nf;
                    m_gq[k][i]   = gate[i];
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [NV*AMP-1:0] ea [2];
        logic [NV-1:0]     ev [2];
        for (int k = 0; k < 2; k++) begin
            ea[k] = '0;
            ev[k] = '0;
            for (int i = 0; i < NV; i++) begin
                ea[k][i*AMP +: AMP] = AMP'(m_acc[k][i] >> (ACC - AMP));
                ev[k][i]            = (m_st[k][i] != M_IDLE);
            end
        end
        check("amp_rz1", 64'(amp0), 64'(ea[0]));
        check("act_rz1", 64'(act0), 64'(ev[0]));
        check("amp_rz0", 64'(amp1), 64'(ea[1]));
        check("act_rz0", 64'(act1), 64'(ev[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clk();
        #1;
        compare_all();
    endtask

    task automatic tick_after(input int gap);
        repeat (gap) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    function automatic logic [7:0] vamp(input logic [NV*AMP-1:0] bus, input int v);
        return bus[v*AMP +: AMP];
    endfunction

    initial begin
        // Reset state
        cyc();
        cyc();
        check("reset_amp", 64'(amp0), 64'd0);
        check("reset_act", 64'(act0), 64'd0);

        // T1: reset mid-attack
        rst = 1'b0; gate = 4'b0001; a = 4'd4;
        repeat (4) tick_after(3);
        check("t1_midattack_act", 64'(act0[0]), 64'd1);
        rst = 1'b1; gate = 4'b0000;
        cyc();
        check("t1_rst_amp", 64'(amp0), 64'd0);
        check("t1_rst_act", 64'(act0), 64'd0);
        cyc();
        rst = 1'b0;
        repeat (3) tick_after(3);
        check("t1_quiet_amp", 64'(amp0), 64'd0);
        check("t1_quiet_act", 64'(act0), 64'd0);

        // T2: full ADSR on voice 0
        a = 4'd0; d = 4'd1; s = 4'd8; r = 4'd1; gate = 4'b0001;
        tick_after(9);
        check("t2_start_act", 64'(act0[0]), 64'd1);
        check("t2_start_amp", 64'(vamp(amp0, 0)), 64'h00);
        tick_after(9); check("t2_att1", 64'(vamp(amp0, 0)), 64'h80);
        tick_after(9); check("t2_att2", 64'(vamp(amp0, 0)), 64'hFF);
        tick_after(9); check("t2_dec1", 64'(vamp(amp0, 0)), 64'hBF);
        tick_after(9); check("t2_dec2", 64'(vamp(amp0, 0)), 64'h88);
        tick_after(9); check("t2_sus", 64'(vamp(amp0, 0)), 64'h88);
        gate = 4'b0000;
        tick_after(9); check("t2_rel0", 64'(vamp(amp0, 0)), 64'h88);
        tick_after(9); check("t2_rel1", 64'(vamp(amp0, 0)), 64'h48);
        tick_after(9); check("t2_rel2", 64'(vamp(amp0, 0)), 64'h08);
        tick_after(9); check("t2_rel3", 64'(vamp(amp0, 0)), 64'h00);
        check("t2_idle_act", 64'(act0[0]), 64'd0);

        // T3: one-clock gate pulse on voice 1
        a = 4'd9; r = 4'd9; gate = 4'b0010;
        cyc();
        gate = 4'b0000;
        tick_after(3); check("t3_attack_act", 64'(act0[1]), 64'd1);
        check("t3_attack_amp", 64'(vamp(amp0, 1)), 64'h00);
        tick_after(3); check("t3_release_act", 64'(act0[1]), 64'd1);
        tick_after(3); check("t3_idle_act", 64'(act0[1]), 64'd0);

        // T4: retrigger during release from 0x88
        a = 4'd0; d = 4'd1; s = 4'd8; r = 4'd1; gate = 4'b0001;
        repeat (5) tick_after(3);
        gate = 4'b0000;
        tick_after(3);
        check("t4_rel_amp", 64'(vamp(amp1, 0)), 64'h88);
        gate = 4'b0001;
        tick_after(3);
        check("t4_rz1_restart", 64'(vamp(amp0, 0)), 64'h00);
        check("t4_rz0_hold", 64'(vamp(amp1, 0)), 64'h88);
        tick_after(3);
        check("t4_rz1_ramp", 64'(vamp(amp0, 0)), 64'h80);
        check("t4_rz0_ramp", 64'(vamp(amp1, 0)), 64'hFF);

        // T5: full sustain on voice 2, then drop sustain to zero
        s = 4'hF; gate = 4'b0101;
        tick_after(3); check("t5_start", 64'(vamp(amp0, 2)), 64'h00);
        tick_after(3); check("t5_att1", 64'(vamp(amp0, 2)), 64'h80);
        tick_after(3); check("t5_max", 64'(vamp(amp0, 2)), 64'hFF);
        tick_after(3); check("t5_sus", 64'(vamp(amp0, 2)), 64'hFF);
        s = 4'h0;
        repeat (3) cyc();
        check("t5_hold_until_tick", 64'(vamp(amp0, 2)), 64'hFF);
        tick_after(0);
        check("t5_sus_zero", 64'(vamp(amp0, 2)), 64'h00);
        check("t5_sus_active", 64'(act0[2]), 64'd1);

        // T6: simultaneous rises on voices 1 and 3
        gate = 4'b0000; r = 4'd0;
        repeat (6) tick_after(2);
        check("t6_all_idle", 64'(act0), 64'd0);
        a = 4'd3; gate = 4'b1010;
        tick_after(2);
        check("t6_active", 64'(act0), 64'b1010);
        for (int k = 1; k <= 6; k++) begin
            tick_after(2);
            check("t6_v1_ramp", 64'(vamp(amp0, 1)), 64'(k * 16));
            check("t6_v3_ramp", 64'(vamp(amp0, 3)), 64'(k * 16));
            check("t6_v0_zero", 64'(vamp(amp0, 0)), 64'd0);
            check("t6_v2_zero", 64'(vamp(amp0, 2)), 64'd0);
        end

        // Random soak
        for (int n = 0; n < 1500; n++) begin
            rst  = ($urandom_range(0, 599) == 0);
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) gate = gate ^ (NV'(1) << $urandom_range(0, NV - 1));
            if ($urandom_range(0, 49) == 0) begin
                a = 4'($urandom_range(0, 6));
                d = 4'($urandom_range(0, 6));
                s = 4'($urandom_range(0, 15));
                r = 4'($urandom_range(0, 6));
            end
            cyc();
        end
        rst  = 1'b0;
        tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
